frame_capture: RTL and testbench

Writes one video frame into the frame BRAM; it is the writer for the BRAM read path that feeds the VGA output mux. On a capture request it waits for the next frame boundary, then packs each active pixel of the post-processing RGB stream into 8-bit RGB332 and writes it, in raster order, to consecutive BRAM addresses. It sits between the pixel pipeline's delayed outputs (pixel, blank, hsync, vsync) and the BRAM write port, and it reports its progress as the shared `bram_state` encoding.

---
 rtl/frame_capture_pkg.sv | 17 +
 rtl/frame_capture.sv | 114 +++++++++++
 tb/tb_frame_capture.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/frame_capture_pkg.sv
// Shared BRAM state encoding and pixel packing used by the frame
// capture writer and the display read path.
package frame_capture_pkg;

    typedef enum logic [1:0] {
        BRAM_IDLE     = 2'b00,
        CAPTURE_FRAME = 2'b01,
        WRITING_FRAME = 2'b10,
        READING_FRAME = 2'b11
    } bram_state_e;

    // RGB888 {R,G,B} -> RGB332 {R[7:5],G[7:5],B[7:6]}
    function automatic logic [7:0] pack_rgb332(input logic [23:0] rgb);
        return {rgb[23:21], rgb[15:13], rgb[7:6]};
    endfunction

endpackage

// File: rtl/frame_capture.sv
// Captures one frame of the post-processing RGB stream into the
// frame BRAM as RGB332, starting at the frame boundary after a request.
module frame_capture
    import frame_capture_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 400,
    parameter int ADDR_W   = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              capture_req,
    input  logic [23:0]       pixel_in,
    input  logic              blank,
    input  logic              vsync,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [7:0]        bram_din,
    output logic [1:0]        bram_state,
    output logic              busy,
    output logic              capture_done,
    output logic              capture_err
);

    localparam int X_W = $clog2(H_ACTIVE + 1);
    localparam int Y_W = $clog2(V_ACTIVE + 1);
    localparam logic [X_W-1:0]    X_MAX     = X_W'(H_ACTIVE);
    localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(V_ACTIVE);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_ACTIVE * V_ACTIVE - 1);

    bram_state_e       state_q, state_d;
    logic              vs_prev_q;
    logic [X_W-1:0]    x_q;
    logic [Y_W-1:0]    y_q;
    logic [ADDR_W-1:0] addr_q;
    logic              line_seen_q;

    logic vs_fall;
    logic in_win;
    logic pix_wr;
    logic last_wr;
    logic early_end;

    assign vs_fall   = vs_prev_q & ~vsync;
    assign in_win    = (x_q < X_MAX) && (y_q < Y_MAX);
    assign pix_wr    = (state_q == WRITING_FRAME) && !blank && in_win;
    assign last_wr   = pix_wr && (addr_q == LAST_ADDR);
    // A final write in the same cycle as vs_fall still completes cleanly.
    assign early_end = (state_q == WRITING_FRAME) && vs_fall && !last_wr;

    assign bram_state = state_q;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BRAM_IDLE:     if (capture_req) state_d = CAPTURE_FRAME;
            CAPTURE_FRAME: if (vs_fall) state_d = WRITING_FRAME;
            WRITING_FRAME: if (last_wr || early_end) state_d = BRAM_IDLE;
            default:       state_d = BRAM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= BRAM_IDLE;
            vs_prev_q    <= 1'b1;
            x_q          <= '0;
            y_q          <= '0;
            addr_q       <= '0;
            line_seen_q  <= 1'b0;
            bram_we      <= 1'b0;
            bram_addr    <= '0;
            bram_din     <= '0;
            busy         <= 1'b0;
            capture_done <= 1'b0;
            capture_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            vs_prev_q    <= vsync;
            busy         <= (state_d != BRAM_IDLE);
            bram_we      <= pix_wr;
            capture_done <= last_wr || early_end;

            if (state_q == BRAM_IDLE && capture_req) begin
                capture_err <= 1'b0;
            end else if (early_end) begin
                capture_err <= 1'b1;
            end

            if (state_q == CAPTURE_FRAME && vs_fall) begin
                x_q         <= '0;
                y_q         <= '0;
                addr_q      <= '0;
                line_seen_q <= 1'b0;
            end else if (state_q == WRITING_FRAME) begin
                if (pix_wr) begin
                    bram_addr <= addr_q;
                    bram_din  <= pack_rgb332(pixel_in);
                    addr_q    <= addr_q + 1'b1;
                end
                if (!blank) begin
                    line_seen_q <= 1'b1;
                    if (x_q != X_MAX) x_q <= x_q + 1'b1;
                end else if (line_seen_q) begin
                    // first blank cycle after an active run closes the line
                    line_seen_q <= 1'b0;
                    x_q         <= '0;
                    if (y_q != Y_MAX) y_q <= y_q + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_capture.sv
// Directed-random bench for frame_capture on a 4x3 capture window
// fed by a 6x4 synthetic raster.
module tb_frame_capture;

    localparam int H = 4;
    localparam int V = 3;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          capture_req = 1'b0;
    logic [23:0]   pixel_in = '0;
    logic          blank = 1'b1;
    logic          vsync = 1'b1;
    logic          bram_we;
    logic [AW-1:0] bram_addr;
    logic [7:0]    bram_din;
    logic [1:0]    bram_state;
    logic          busy;
    logic          capture_done;
    logic          capture_err;

    frame_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .ADDR_W(AW)) dut (
        .clk(clk), .reset_n(reset_n), .capture_req(capture_req),
        .pixel_in(pixel_in), .blank(blank), .vsync(vsync),
        .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_state(bram_state), .busy(busy),
        .capture_done(capture_done), .capture_err(capture_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [23:0] pix [4][6];
    int          got_addr[$];
    logic [7:0]  got_din[$];
    int          done_n;
    logic        done_we;
    int          done_addr;
    logic [1:0]  fall_state;
    logic        fall_done;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference packing done arithmetically on the colour channels.
    function automatic logic [7:0] ref_pack(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]) / 32;
        g = int'(p[15:8]) / 32;
        b = int'(p[7:0]) / 64;
        return 8'(r * 32 + g * 4 + b);
    endfunction

    task automatic clear_log();
        got_addr.delete();
        got_din.delete();
        done_n = 0;
        done_we = 1'b0;
        done_addr = -1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (bram_we) begin
            got_addr.push_back(int'(bram_addr));
            got_din.push_back(bram_din);
        end
        if (capture_done) begin
            done_n++;
            done_we = bram_we;
            done_addr = int'(bram_addr);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_we"}, 32'(bram_we), 0);
        chk({tag, "_addr"}, 32'(bram_addr), 0);
        chk({tag, "_din"}, 32'(bram_din), 0);
        chk({tag, "_state"}, 32'(bram_state), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(capture_done), 0);
        chk({tag, "_err"}, 32'(capture_err), 0);
    endtask

    task automatic run_frame(input int lines, input bit req_fall,
                             input bit req_mid, input int rst_at,
                             input bit force_px);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 6; x++)
                pix[y][x] = 24'($urandom);
        if (force_px) pix[0][0] = 24'hFF8040;
        vsync = 1'b1;
        blank = 1'b1;
        repeat (3) tick();
        vsync = 1'b0;
        capture_req = req_fall;
        tick();
        capture_req = 1'b0;
        fall_state = bram_state;
        fall_done = capture_done;
        tick();
        vsync = 1'b1;
        repeat (2) tick();
        for (int y = 0; y < lines; y++) begin
            for (int x = 0; x < 6; x++) begin
                blank = 1'b0;
                pixel_in = pix[y][x];
                capture_req = req_mid && (y == 1) && (x == 2);
                tick();
                capture_req = 1'b0;
                if (!reset_n) begin
                    reset_n = 1'b1;
                end else if (rst_at >= 0 && bram_we &&
                             int'(bram_addr) == rst_at) begin
                    reset_n = 1'b0;
                    #1;
                    check_reset_outputs("midreset");
                end
            end
            blank = 1'b1;
            repeat (3) tick();
        end
        repeat (3) tick();
    endtask

    task automatic check_writes(input string tag, input int n);
        chk({tag, "_count"}, 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            chk({tag, "_addr"}, 32'(got_addr[i]), 32'(i));
            chk({tag, "_din"}, 32'(got_din[i]),
                32'(ref_pack(pix[i / H][i % H])));
        end
    endtask

    task automatic pulse_req();
        capture_req = 1'b1;
        tick();
        capture_req = 1'b0;
    endtask

    initial begin
        clear_log();
        #1;
        check_reset_outputs("reset");
        repeat (2) tick();
        reset_n = 1'b1;
        tick();

        // Frame without a request writes nothing.
        clear_log();
        run_frame(4, 1'b0, 1'b0, -1, 1'b0);
        chk("idle_writes", 32'(got_addr.size()), 0);

        // Full capture.
        pulse_req();
        chk("armed_state", 32'(bram_state), 32'h1);
        chk("armed_busy", 32'(busy), 1);
        clear_log();
        run_frame(4, 1'b0, 1'b0, -1, 1'b1);
        chk("full_fall_state", 32'(fall_state), 32'h2);
        check_writes("full", H * V);
        chk("full_pack_const", 32'(got_din.size() > 0 ? got_din[0] : 8'h00),
            32'hF1);
        chk("full_done_n", 32'(done_n), 1);
        chk("full_done_we", 32'(done_we), 1);
        chk("full_done_addr", 32'(done_addr), H * V - 1);
        chk("full_end_state", 32'(bram_state), 0);
        chk("full_end_busy", 32'(busy), 0);
        chk("full_end_err", 32'(capture_err), 0);

        // Early end after two lines.
        pulse_req();
        clear_log();
        run_frame(2, 1'b0, 1'b0, -1, 1'b0);
        check_writes("early", 2 * H);
        chk("early_done_pre", 32'(done_n), 0);
        chk("early_busy_pre", 32'(busy), 1);
        clear_log();
        run_frame(4, 1'b0, 1'b0, -1, 1'b0);
        chk("early_done_at_fall", 32'(fall_done), 1);
        chk("early_state_at_fall", 32'(fall_state), 0);
        chk("early_done_n", 32'(done_n), 1);
        chk("early_extra_writes", 32'(got_addr.size()), 0);
        chk("early_err", 32'(capture_err), 1);
        chk("early_state", 32'(bram_state), 0);
        pulse_req();
        chk("err_cleared", 32'(capture_err), 0);

        // Request while writing is ignored.
        clear_log();
        run_frame(4, 1'b0, 1'b1, -1, 1'b0);
        check_writes("midreq", H * V);
        chk("midreq_done_n", 32'(done_n), 1);
        chk("midreq_state", 32'(bram_state), 0);

        // Reset at address 5, then a fresh capture.
        pulse_req();
        clear_log();
        run_frame(4, 1'b0, 1'b0, 5, 1'b0);
        check_writes("rst", 6);
        chk("rst_done_n", 32'(done_n), 0);
        chk("rst_state", 32'(bram_state), 0);
        pulse_req();
        clear_log();
        run_frame(4, 1'b0, 1'b0, -1, 1'b0);
        check_writes("after_rst", H * V);

        // Request coincident with vs_fall only arms.
        clear_log();
        run_frame(4, 1'b1, 1'b0, -1, 1'b0);
        chk("same_fall_state", 32'(fall_state), 32'h1);
        chk("same_writes", 32'(got_addr.size()), 0);
        chk("same_busy", 32'(busy), 1);
        clear_log();
        run_frame(4, 1'b0, 1'b0, -1, 1'b0);
        check_writes("same_next", H * V);
        chk("same_done_n", 32'(done_n), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
